mem_arbiter: RTL and testbench

- Sequences the single-ported RAM between instruction fetch and data access; generates the ihit/dhit strobes the control unit consumes.
- Sits between the datapath (iREN/dREN/dWEN requests from the control unit) and the RAM model.
- Registered-grant FSM with data-side priority and a starvation guard for fetch.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter_streak_counter.sv | 45 ++++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds the arbiter state encoding, the default data-streak limit and the word type.
package mem_arbiter_pkg;

  localparam int WORD_W          = 32;
  localparam int MAX_DSTREAK_DEF = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } arb_state_t;

  // A data-side access is requested by either a read or a write strobe.
  function automatic logic d_req(input logic ren, input logic wen);
    return ren | wen;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and RAM-side signals of mem_arbiter.
// Perf counter signals exist only when MEM_ARB_PERF_EN is defined.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramready;

`ifdef MEM_ARB_PERF_EN
  word_t             icount;
  word_t             dcount;
  word_t             waitcycles;
`endif

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
`ifdef MEM_ARB_PERF_EN
    output icount, dcount, waitcycles,
`endif
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
`ifdef MEM_ARB_PERF_EN
    input  icount, dcount, waitcycles,
`endif
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_streak_counter.sv
// Up-counter with synchronous clear and optional saturation at MAX.
// Used for the data-streak guard (saturating) and the wrapping perf counters.
module mem_arbiter_streak_counter #(
  parameter int          WIDTH    = 3,
  parameter int unsigned MAX      = 4,
  parameter bit          SATURATE = 1'b1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_r;
  logic             at_max_s;

  // Saturation only matters for the streak guard; perf counters wrap.
  always_comb begin
    at_max_s = 1'b0;
    if (SATURATE) begin
      at_max_s = (count_r == MAX_V);
    end else begin
      at_max_s = 1'b0;
    end
  end

  // Count register: clear dominates increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && !at_max_s) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data access, with
// data priority and a fetch starvation guard. MEM_ARB_PERF_EN adds perf counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
)(
  input logic        CLK,
  input logic        nRST,
  mem_arbiter_if.arb bus
);

  localparam int                    STREAK_W   = $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  arb_state_t          state_r;
  logic [STREAK_W-1:0] streak_s;

  logic                i_req_s;
  logic                d_req_s;
  logic                streak_full_s;
  logic                go_d_s;
  logic                go_i_s;
  logic                streak_inc_s;
  logic                streak_clr_s;

  logic                ram_ren_s;
  logic                ram_wen_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [DATA_W-1:0]   ram_store_s;
  logic                ihit_s;
  logic                dhit_s;
  logic [DATA_W-1:0]   iload_s;
  logic [DATA_W-1:0]   dload_s;

  // Arbitration decision taken in IDLE; fetch wins only once the data streak is full.
  always_comb begin
    i_req_s       = bus.iREN;
    d_req_s       = d_req(bus.dREN, bus.dWEN);
    streak_full_s = (streak_s == STREAK_MAX);
    go_d_s        = 1'b0;
    go_i_s        = 1'b0;
    if (state_r == IDLE) begin
      go_d_s = d_req_s && !(i_req_s && streak_full_s);
      go_i_s = !go_d_s && i_req_s;
    end else begin
      go_d_s = 1'b0;
      go_i_s = 1'b0;
    end
    streak_inc_s = go_d_s && i_req_s;
    streak_clr_s = go_i_s || ((state_r == IDLE) && !i_req_s);
  end

  mem_arbiter_streak_counter #(
    .WIDTH    (STREAK_W),
    .MAX      (MAX_DSTREAK),
    .SATURATE (1'b1)
  ) u_streak (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (streak_clr_s),
    .inc   (streak_inc_s),
    .count (streak_s)
  );

  // Grant FSM: a grant ends on ramready or when the requester withdraws.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (go_d_s) begin
            state_r <= DGRANT;
          end else if (go_i_s) begin
            state_r <= IGRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        IGRANT: begin
          if (!i_req_s || bus.ramready) begin
            state_r <= IDLE;
          end else begin
            state_r <= IGRANT;
          end
        end
        DGRANT: begin
          if (!d_req_s || bus.ramready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DGRANT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // RAM side follows the granted requester's live inputs so a withdrawn request drops the enables at once.
  always_comb begin
    ram_ren_s   = 1'b0;
    ram_wen_s   = 1'b0;
    ram_addr_s  = '0;
    ram_store_s = '0;
    ihit_s      = 1'b0;
    dhit_s      = 1'b0;
    iload_s     = '0;
    dload_s     = '0;
    case (state_r)
      IGRANT: begin
        ram_ren_s  = i_req_s;
        ram_addr_s = bus.iaddr;
        ihit_s     = i_req_s && bus.ramready;
        if (ihit_s) begin
          iload_s = bus.ramload;
        end else begin
          iload_s = '0;
        end
      end
      DGRANT: begin
        ram_wen_s   = bus.dWEN;
        ram_ren_s   = bus.dREN && !bus.dWEN;
        ram_addr_s  = bus.daddr;
        ram_store_s = bus.dstore;
        dhit_s      = d_req_s && bus.ramready;
        if (dhit_s && bus.dREN && !bus.dWEN) begin
          dload_s = bus.ramload;
        end else begin
          dload_s = '0;
        end
      end
      default: begin
        ram_ren_s = 1'b0;
      end
    endcase
  end

  assign bus.ramREN   = ram_ren_s;
  assign bus.ramWEN   = ram_wen_s;
  assign bus.ramaddr  = ram_addr_s;
  assign bus.ramstore = ram_store_s;
  assign bus.ihit     = ihit_s;
  assign bus.dhit     = dhit_s;
  assign bus.iload    = iload_s;
  assign bus.dload    = dload_s;

`ifdef MEM_ARB_PERF_EN
  logic  wait_s;
  word_t icount_s;
  word_t dcount_s;
  word_t waitcycles_s;

  // A wait cycle is any grant-state cycle the RAM has not finished.
  always_comb begin
    if (state_r != IDLE) begin
      wait_s = !bus.ramready;
    end else begin
      wait_s = 1'b0;
    end
  end

  mem_arbiter_streak_counter #(.WIDTH(WORD_W), .MAX(0), .SATURATE(1'b0)) u_icount (
    .clk(CLK), .rst_n(nRST), .clr(1'b0), .inc(ihit_s), .count(icount_s)
  );

  mem_arbiter_streak_counter #(.WIDTH(WORD_W), .MAX(0), .SATURATE(1'b0)) u_dcount (
    .clk(CLK), .rst_n(nRST), .clr(1'b0), .inc(dhit_s), .count(dcount_s)
  );

  mem_arbiter_streak_counter #(.WIDTH(WORD_W), .MAX(0), .SATURATE(1'b0)) u_waitcycles (
    .clk(CLK), .rst_n(nRST), .clr(1'b0), .inc(wait_s), .count(waitcycles_s)
  );

  assign bus.icount     = icount_s;
  assign bus.dcount     = dcount_s;
  assign bus.waitcycles = waitcycles_s;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed arbitration scenarios plus randomized
// traffic against a memory/queue reference model; perf counters under MEM_ARB_PERF_EN.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAXS = MAX_DSTREAK_DEF;

  logic CLK;
  logic nRST;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXS)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int    n_chk  = 0;
  int    n_pass = 0;
  word_t ref_mem[int unsigned];
  word_t ram_mem[int unsigned];
  word_t iq[$];
  word_t dq[$];
  string order_s;
  int    ram_fixed;
  bit    i_pending;
  int    dcnt_i;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic word_t init_word(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic word_t ref_rd(input word_t a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic word_t ram_rd(input word_t a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: hit with empty scoreboard at %0t", name, $time);
  endtask

  // RAM model: completes an access after a per-access delay, garbage on ramload otherwise.
  initial begin
    bit active;
    int cnt;
    int cur;
    active = 1'b0; cnt = 0; cur = 0;
    bus.ramready = 1'b0;
    bus.ramload  = '0;
    forever begin
      @(posedge CLK); #2;
      if (bus.ramREN || bus.ramWEN) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          cur    = (ram_fixed >= 0) ? ram_fixed : int'($urandom_range(0, 3));
        end
        if (cnt >= cur) begin
          bus.ramready = 1'b1;
          bus.ramload  = bus.ramREN ? ram_rd(bus.ramaddr) : $urandom;
          active       = 1'b0;
        end else begin
          bus.ramready = 1'b0;
          bus.ramload  = $urandom;
          cnt++;
        end
      end else begin
        active       = 1'b0;
        bus.ramready = 1'b0;
        bus.ramload  = $urandom;
      end
      @(negedge CLK);
      if (bus.ramWEN && bus.ramready) ram_mem[bus.ramaddr] = bus.ramstore;
    end
  end

  // Monitor: pops the scoreboard on every hit and checks per-cycle invariants.
  always @(negedge CLK) begin
    word_t exp;
    chk("hit_exclusive", 32'(bus.ihit & bus.dhit), 32'd0);
    chk("rw_exclusive", 32'(bus.ramREN & bus.ramWEN), 32'd0);
    if (bus.ramWEN) begin
      chk("ram_waddr", bus.ramaddr, bus.daddr);
      chk("ram_wdata", bus.ramstore, bus.dstore);
    end
    if (bus.ihit) begin
      order_s = {order_s, "I"};
      if (i_pending) chk("starve_bound", 32'(dcnt_i <= MAXS + 1), 32'd1);
      if (iq.size() == 0) fail_now("ihit_unexpected");
      else begin
        exp = iq.pop_front();
        chk("iload", bus.iload, exp);
      end
    end else begin
      chk("iload_zero", bus.iload, 32'd0);
    end
    if (bus.dhit) begin
      order_s = {order_s, "D"};
      if (i_pending) dcnt_i++;
      if (dq.size() == 0) fail_now("dhit_unexpected");
      else begin
        exp = dq.pop_front();
        chk("dload", bus.dload, exp);
      end
    end else begin
      chk("dload_zero", bus.dload, 32'd0);
    end
  end

  task automatic i_fetch(input word_t a, output int lat);
    bit got;
    got = 1'b0; lat = 0;
    bus.iaddr = a; bus.iREN = 1'b1;
    iq.push_back(ref_rd(a));
    dcnt_i = 0; i_pending = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      if (bus.ihit) begin got = 1'b1; lat = k; break; end
    end
    chk("ihit_seen", 32'(got), 32'd1);
    chk("ihit_latency_min", 32'(lat >= 1), 32'd1);
    @(posedge CLK); #1;
    bus.iREN = 1'b0; i_pending = 1'b0;
  endtask

  task automatic d_access(input word_t a, input logic rd, input logic wr, input word_t wd, output int lat);
    bit got;
    got = 1'b0; lat = 0;
    bus.daddr = a; bus.dREN = rd; bus.dWEN = wr; bus.dstore = wd;
    if (wr) begin
      ref_mem[a] = wd;
      dq.push_back(32'd0);
    end else begin
      dq.push_back(ref_rd(a));
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      if (bus.dhit) begin got = 1'b1; lat = k; break; end
    end
    chk("dhit_seen", 32'(got), 32'd1);
    chk("dhit_latency_min", 32'(lat >= 1), 32'd1);
    @(posedge CLK); #1;
    bus.dREN = 1'b0; bus.dWEN = 1'b0;
  endtask

  initial begin
    int  lat;
    int  lat2;
    bit  got;
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h48;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    ram_fixed = 7; i_pending = 1'b0; dcnt_i = 0; order_s = "";

    // Reset held with a fetch request pending.
    repeat (3) begin
      @(negedge CLK);
      chk("rst_ihit", bus.ihit, 32'd0);
      chk("rst_ramREN", bus.ramREN, 32'd0);
      chk("rst_ramWEN", bus.ramWEN, 32'd0);
      chk("rst_iload", bus.iload, 32'd0);
      chk("rst_ramaddr", bus.ramaddr, 32'd0);
`ifdef MEM_ARB_PERF_EN
      chk("rst_icount", bus.icount, 32'd0);
`endif
    end
    iq.push_back(ref_rd(32'h48));
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk("release_idle_ramREN", bus.ramREN, 32'd0);
    @(negedge CLK);
    chk("release_igrant_ramREN", bus.ramREN, 32'd1);
    chk("release_igrant_addr", bus.ramaddr, 32'h48);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.ihit) begin got = 1'b1; break; end
      @(negedge CLK);
    end
    chk("release_ihit_seen", 32'(got), 32'd1);
    @(posedge CLK); #1;
    bus.iREN = 1'b0;

    // Fetch with two RAM wait cycles.
    ram_fixed = 2;
    ref_mem[32'h40] = 32'h8C22_0004;
    ram_mem[32'h40] = 32'h8C22_0004;
    i_fetch(32'h40, lat);
    chk("fetch_latency", 32'(lat), 32'd3);
    @(negedge CLK);
    chk("fetch_ihit_one_cycle", bus.ihit, 32'd0);
    @(posedge CLK); #1;

    // Simultaneous requests: data side first.
    ram_fixed = 1; order_s = "";
    fork
      i_fetch(32'h44, lat);
      d_access(32'h100, 1'b1, 1'b0, 32'd0, lat2);
    join
    chk_str("priority_order", order_s, "DI");

    // Starvation guard: fetch slips in after MAXS data grants.
    ram_fixed = 0; order_s = "";
    fork
      i_fetch(32'h4C, lat);
      begin
        for (int j = 0; j < 5; j++) d_access(32'h110 + 32'(4 * j), 1'b0, 1'b1, $urandom, lat2);
      end
    join
    chk_str("starvation_order", order_s, "DDDDID");

    // Abort: data read withdrawn before ramready.
    ram_fixed = 7; order_s = "";
    bus.daddr = 32'h104; bus.dREN = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("abort_pre_ramREN", bus.ramREN, 32'd1);
    @(posedge CLK); #1;
    bus.dREN = 1'b0;
    #1;
    chk("abort_ramREN_drop", bus.ramREN, 32'd0);
    chk("abort_no_dhit", bus.dhit, 32'd0);
    @(posedge CLK); #1;
    ram_fixed = 0;
    i_fetch(32'h40, lat);
    chk("abort_then_idle_latency", 32'(lat), 32'd1);
    chk_str("abort_order", order_s, "I");

    // Reset in the middle of a write.
    ram_fixed = 7;
    bus.daddr = 32'h108; bus.dstore = 32'hDEAD_BEEF; bus.dWEN = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_pre_ramWEN", bus.ramWEN, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_ramWEN", bus.ramWEN, 32'd0);
    chk("midrst_ramaddr", bus.ramaddr, 32'd0);
    chk("midrst_dhit", bus.dhit, 32'd0);
    bus.dWEN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Randomized concurrent traffic.
    ram_fixed = -1;
    fork
      begin
        int g;
        int il;
        for (int j = 0; j < 20; j++) begin
          g = int'($urandom_range(0, 3));
          repeat (g) begin @(posedge CLK); #1; end
          i_fetch(word_t'($urandom_range(0, 63)) << 2, il);
        end
      end
      begin
        int g;
        int k;
        int dl;
        for (int j = 0; j < 25; j++) begin
          g = int'($urandom_range(0, 3));
          repeat (g) begin @(posedge CLK); #1; end
          k = int'($urandom_range(0, 2));
          d_access(32'h100 + (word_t'($urandom_range(0, 15)) << 2), k != 1, k != 0, $urandom, dl);
        end
      end
    join
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

`ifdef MEM_ARB_PERF_EN
    // Perf counters from a fresh reset.
    @(posedge CLK); #1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    ram_fixed = 2;
    for (int j = 0; j < 3; j++) i_fetch(32'h40 + 32'(4 * j), lat);
    ram_fixed = 0;
    d_access(32'h120, 1'b0, 1'b1, 32'h1234_5678, lat2);
    chk("perf_icount", bus.icount, 32'd3);
    chk("perf_dcount", bus.dcount, 32'd1);
    chk("perf_waitcycles", bus.waitcycles, 32'd6);
`endif

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog expired");
  end

endmodule
